// File: rtl/fpu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_uart_tx
// Description : Buffers 32-bit FPU result words and streams each one out as
//               four 8N1 UART bytes, least significant byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic [15:0]                 CLKS_PER_BIT,
  input  logic                        result_valid,
  input  logic [31:0]                 result_data,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  logic [31:0]         r_shift;
  logic [15:0]         r_period, r_bit_cnt;
  logic [2:0]          r_bit_idx;
  logic [1:0]          r_byte_idx;
  logic                r_tx_serial, r_tx_active, r_done_pend, r_tx_done;
  logic                w_full, w_pop, w_push, w_tick, w_word_end;

  assign w_full = (r_count == c_depth);
  assign w_tick = (r_bit_cnt == r_period - 16'd1);
  assign w_push = result_valid && (!w_full || w_pop);

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_word_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = START;
        end
      end
      START: if (w_tick) w_next_state = DATA;
      DATA:  if (w_tick && r_bit_idx == 3'd7) w_next_state = STOP;
      STOP: begin
        if (w_tick) begin
          w_word_end   = (r_byte_idx == 2'd3);
          w_next_state = (r_byte_idx == 2'd3) ? IDLE : START;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst_l && w_push) r_mem[r_wr_ptr] <= result_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (result_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // The whole word is shifted right one bit per data bit, so bit 0 is always the next data bit.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_shift    <= '0;
      r_period   <= 16'd1;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else if (w_pop) begin
      r_shift    <= r_mem[r_rd_ptr];
      r_period   <= (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else if (r_state != IDLE) begin
      r_bit_cnt <= w_tick ? 16'd0 : r_bit_cnt + 16'd1;
      if (w_tick && r_state == DATA) begin
        r_shift   <= {1'b0, r_shift[31:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_tick && r_state == STOP) r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  // Line outputs trail the state by one cycle; Done lands on the idle cycle after the last stop bit.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_tx_serial <= 1'b1;
      r_tx_active <= 1'b0;
      r_done_pend <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_serial <= (r_state == START) ? 1'b0 :
                     (r_state == DATA)  ? r_shift[0] : 1'b1;
      r_tx_active <= (r_state != IDLE);
      r_done_pend <= w_word_end;
      r_tx_done   <= r_done_pend;
    end
  end

  assign o_Tx_Serial = r_tx_serial;
  assign o_Tx_Active = r_tx_active;
  assign o_Tx_Done   = r_tx_done;
  assign fifo_full   = w_full;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_uart_tx
// Description : Randomized and directed bench for fpu_result_uart_tx against a
//               frame-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_uart_tx;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [15:0] clks_per_bit = 16'd4;
  logic        result_valid = 1'b0;
  logic [31:0] result_data = '0;
  logic        tx_serial, tx_active, tx_done, fifo_full, overflow;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  fpu_result_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .CLKS_PER_BIT (clks_per_bit),
    .result_valid (result_valid),
    .result_data  (result_data),
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Active  (tx_active),
    .o_Tx_Done    (tx_done),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: queued words plus the frame currently on the line.
  logic [31:0] m_q[$];
  int          m_busy = 0, m_ft = -1, m_fp = 1, m_pend_p = 1;
  logic [31:0] m_fw = '0, m_pend_w = '0;
  bit          m_pend = 0, m_ovf = 0, m_done = 0;

  int   starts[$], dones[$];
  int   peak = 0;
  logic prev_active = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit k (0..39) of a word frame: 4 x {start, 8 data LSB first, stop}.
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int b, j;
    b = k / 10;
    j = k % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return w[8*b + j - 1];
  endfunction

  task automatic model_edge();
    int p;
    bit pop, push_ok;
    m_done = 0;
    if (!rst_l) begin
      m_q.delete();
      m_busy = 0;
      m_ft   = -1;
      m_pend = 0;
      m_ovf  = 0;
      return;
    end
    if (m_ft >= 0) begin
      m_ft++;
      if (m_ft == 40 * m_fp) begin
        m_ft   = -1;
        m_done = 1;
      end
    end
    if (m_pend) begin
      m_ft   = 0;
      m_fw   = m_pend_w;
      m_fp   = m_pend_p;
      m_pend = 0;
    end
    pop     = (m_busy == 0) && (m_q.size() > 0);
    push_ok = result_valid && (m_q.size() < FIFO_DEPTH || pop);
    if (result_valid && !push_ok) m_ovf = 1;
    if (m_busy > 0) m_busy--;
    if (pop) begin
      p        = (clks_per_bit == 16'd0) ? 1 : int'(clks_per_bit);
      m_pend   = 1;
      m_pend_w = m_q.pop_front();
      m_pend_p = p;
      m_busy   = 40 * p;
    end
    if (push_ok) m_q.push_back(result_data);
  endtask

  task automatic step();
    logic [7:0] exp_v, got_v;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    exp_v = {(m_ft < 0) ? 1'b1 : exp_bit(m_fw, m_ft / m_fp), (m_ft >= 0), m_done,
             (m_q.size() == FIFO_DEPTH), m_ovf, 3'(m_q.size())};
    got_v = {tx_serial, tx_active, tx_done, fifo_full, overflow, fifo_count};
    check_val($sformatf("line_state@%0d", cyc), 64'(got_v), 64'(exp_v));
    if (tx_active && !prev_active) starts.push_back(cyc);
    if (tx_done) dones.push_back(cyc);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    prev_active = tx_active;
  endtask

  task automatic push(input logic [31:0] d);
    result_valid = 1'b1;
    result_data  = d;
    step();
    result_valid = 1'b0;
  endtask

  task automatic clear_marks();
    starts.delete();
    dones.delete();
    peak = 0;
  endtask

  task automatic do_reset();
    rst_l        = 1'b0;
    result_valid = 1'b1;
    result_data  = $urandom();
    step();
    step();
    rst_l        = 1'b1;
    result_valid = 1'b0;
    step();
    check_val("reset_count", 64'(fifo_count), 64'd0);
    check_val("reset_serial", 64'(tx_serial), 64'd1);
    check_val("reset_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    result_valid = 1'b0;
    while (!(m_q.size() == 0 && m_ft < 0 && !m_pend && fifo_count == 0 && !tx_active) && n < limit) begin
      step();
      n++;
    end
    check_val("drain_timeout", 64'(n < limit), 64'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Single word at 4 clocks/bit
    clks_per_bit = 16'd4;
    clear_marks();
    push(32'h3F80_0000);
    drain(400);
    check_val("single_dones", 64'(dones.size()), 64'd1);
    if (dones.size() == 1 && starts.size() == 1)
      check_val("single_len", 64'(dones[0] - starts[0]), 64'd160);

    // Back-to-back at 2 clocks/bit
    clks_per_bit = 16'd2;
    clear_marks();
    push(32'h4049_0FDB);
    push(32'hC000_0000);
    drain(400);
    check_val("b2b_peak", 64'(peak), 64'd1);
    check_val("b2b_dones", 64'(dones.size()), 64'd2);
    if (dones.size() == 2 && starts.size() == 2) begin
      check_val("b2b_len0", 64'(dones[0] - starts[0]), 64'd80);
      check_val("b2b_gap", 64'(starts[1] - dones[0]), 64'd1);
      check_val("b2b_len1", 64'(dones[1] - starts[1]), 64'd80);
    end

    // Overflow: six consecutive pushes into a depth-4 FIFO
    clks_per_bit = 16'd8;
    clear_marks();
    for (int i = 0; i < 6; i++) push(32'hA000_0000 + 32'(i));
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_full", 64'(fifo_full), 64'd1);
    drain(3000);
    check_val("ovf_words", 64'(dones.size()), 64'd5);
    do_reset();

    // Push while full on the pop cycle
    clks_per_bit = 16'd2;
    clear_marks();
    for (int i = 0; i < 5; i++) push($urandom());
    check_val("pp_full_before", 64'(fifo_full), 64'd1);
    if (starts.size() >= 1) begin
      wait_until(starts[0] + 79);
      push($urandom());
      check_val("pp_done", 64'(tx_done), 64'd1);
      check_val("pp_count", 64'(fifo_count), 64'd4);
      check_val("pp_overflow", 64'(overflow), 64'd0);
    end else begin
      check_val("pp_start_seen", 64'(starts.size()), 64'd1);
    end
    drain(2000);

    // Reset in the middle of byte 2 data
    clks_per_bit = 16'd4;
    clear_marks();
    push(32'h1234_5678);
    push(32'hDEAD_BEEF);
    if (starts.size() == 0) step();
    if (starts.size() >= 1) wait_until(starts[0] + 25 * 4);
    rst_l = 1'b0;
    step();
    check_val("abort_serial", 64'(tx_serial), 64'd1);
    check_val("abort_count", 64'(fifo_count), 64'd0);
    rst_l = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_val("abort_no_done", 64'(dones.size()), 64'd0);
    push(32'h0000_0001);
    drain(400);
    check_val("abort_fresh_done", 64'(dones.size()), 64'd1);

    // Bit-rate change during byte 1
    clks_per_bit = 16'd4;
    clear_marks();
    push($urandom());
    push($urandom());
    if (starts.size() >= 1) wait_until(starts[0] + 15 * 4);
    clks_per_bit = 16'd10;
    drain(1000);
    check_val("rate_dones", 64'(dones.size()), 64'd2);
    if (dones.size() == 2 && starts.size() == 2) begin
      check_val("rate_len0", 64'(dones[0] - starts[0]), 64'd160);
      check_val("rate_len1", 64'(dones[1] - starts[1]), 64'd400);
    end

    // Random traffic, rate changes (including 0) and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) clks_per_bit = 16'($urandom_range(0, 5));
      rst_l        = ($urandom_range(0, 1999) != 0);
      result_valid = ($urandom_range(0, 15) == 0);
      result_data  = $urandom();
      step();
    end
    rst_l = 1'b1;
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_result_uart_tx.md
FPU_RESULT_UART_TX -- requirements
Module: fpu_result_uart_tx

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, the number of 32-bit result words buffered (power of two, minimum 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL provide the following ports, one per line (name, direction, width, meaning):
  clk  input  1  system clock; all state changes on its rising edge.
  rst_l  input  1  synchronous active-low reset.
  CLKS_PER_BIT  input  16  clk cycles per UART bit.
  result_valid  input  1  one-cycle strobe: result_data holds a completed FPU result.
  result_data  input  32  single-precision result word from the FPU top.
  o_Tx_Serial  output  1  UART TX line, 8N1, idle high.
  o_Tx_Active  output  1  high while a word frame is being shifted out.
  o_Tx_Done  output  1  one-cycle pulse after the last stop bit of a word.
  fifo_full  output  1  FIFO holds FIFO_DEPTH words.
  fifo_count  output  clog2(FIFO_DEPTH)+1  words currently buffered.
  overflow  output  1  sticky; a push was dropped.

Function
REQ-004 Each cycle with result_valid=1 SHALL be a push of result_data into a FIFO_DEPTH-deep FIFO; the word becomes visible to the FSM on the next cycle.
REQ-005 A push while full with no same-cycle pop SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL set to 1 and hold until reset.
REQ-006 A push and a pop in the same cycle SHALL both take effect, including when full; fifo_count SHALL be unchanged.
REQ-007 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_full = (fifo_count == FIFO_DEPTH).
REQ-008 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-009 In IDLE with fifo_count>0, the FSM SHALL pop the head word into a 32-bit shift register, latch CLKS_PER_BIT into a bit-period register, clear the byte index, and go to START. A latched value of 0 SHALL be treated as 1.
REQ-010 START: o_Tx_Serial=0 for one bit period, then go to DATA.
REQ-011 DATA: drive the 8 bits of the current byte LSB first, one bit period each, then go to STOP.
REQ-012 STOP: o_Tx_Serial=1 for one bit period.
  After byte index 0..2, increment the byte index and go to START with no idle gap.
  After byte index 3, pulse o_Tx_Done for one cycle and go to IDLE.
REQ-013 Byte order SHALL be result_data[7:0], [15:8], [23:16], [31:24].
REQ-014 A word frame SHALL last exactly 40*P cycles, where P is the latched bit period. A CLKS_PER_BIT change mid-word SHALL NOT affect the word in flight.
REQ-015 With IDLE and an empty FIFO, o_Tx_Serial SHALL fall on the second rising edge after the edge that samples result_valid=1.
REQ-016 If a word is buffered when o_Tx_Done pulses, the next word's start bit SHALL begin on the cycle after the Done cycle. That is one idle-high cycle plus the stop bit.
REQ-017 o_Tx_Active SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-018 The bit-period counter SHALL count 0..P-1 and advance the state or bit on P-1.

Reset
REQ-019 While rst_l=0 at a clock edge, the block SHALL set o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, overflow=0, fifo_count=0, fifo_full=0, state=IDLE, and clear all pointers and counters.
REQ-020 A reset mid-frame SHALL abort the frame: the line returns high on the next cycle and buffered words are discarded. No o_Tx_Done SHALL pulse for the aborted word.
REQ-021 result_valid during reset SHALL be ignored.

Verification
REQ-022 Single word: CLKS_PER_BIT=4, push 0x3F800000 -> bytes 0x00,0x00,0x80,0x3F on the line. Each byte shows a start bit of 0, data LSB first, and a stop bit of 1, each bit 4 cycles. o_Tx_Done pulses 160 cycles after the start-bit fall.
REQ-023 Back-to-back: CLKS_PER_BIT=2, push 0x40490FDB then 0xC0000000 on consecutive cycles -> two frames of 80 cycles each, separated by exactly one idle-high cycle. fifo_count peaks at 1 and two Done pulses occur.
REQ-024 Overflow: FIFO_DEPTH=4, CLKS_PER_BIT=8, push 6 words on consecutive cycles -> the first word is popped, 4 are buffered, and the 6th is dropped. overflow=1, fifo_full=1, and exactly 5 words are transmitted in order.
REQ-025 Full push+pop: hold the FIFO full and strobe result_valid on the cycle the FSM pops -> the word is accepted, fifo_count stays 4, and overflow stays 0.
REQ-026 Reset mid-frame: assert rst_l=0 during DATA of byte 2 -> o_Tx_Serial=1 on the next cycle, fifo_count=0, and no o_Tx_Done. A fresh push of 0x00000001 after reset transmits 0x01,0x00,0x00,0x00.
REQ-027 Mid-word rate change: switch CLKS_PER_BIT from 4 to 10 during byte 1 -> the current word keeps 4-cycle bits and the next word uses 10-cycle bits.
